// File: rtl/kl_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// kl_arbiter_pkg
// Shared KLink definitions for the 2:1 request arbiter.
//   - KLink field widths and packed request/response widths
//   - kl_req_t : packed request bundle (addr, wen, wdata, wmask, size, srcid)
//   - kl_gnt_e : grant index (which master owns the downlink)
//   - kl_pick  : round-robin pick between two requesters
// -----------------------------------------------------------------------------
package kl_arbiter_pkg;

    localparam int KL_AW  = 32;
    localparam int KL_DW  = 64;
    localparam int KL_MW  = 8;
    localparam int KL_SW  = 3;
    localparam int KL_IDW = 5;

    localparam int KL_REQ_W  = KL_AW + 1 + KL_DW + KL_MW + KL_SW + KL_IDW; // 113
    localparam int KL_RESP_W = KL_DW + KL_SW + KL_IDW;                     // 72

    typedef struct packed {
        logic [KL_AW-1:0]  addr;
        logic              wen;
        logic [KL_DW-1:0]  wdata;
        logic [KL_MW-1:0]  wmask;
        logic [KL_SW-1:0]  size;
        logic [KL_IDW-1:0] srcid;
    } kl_req_t;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } kl_gnt_e;

    // With both masters requesting, the one that did not win last time goes.
    // Passing last = GNT_M1 permanently turns this into fixed priority for m0.
    function automatic kl_gnt_e kl_pick(input logic v0, input logic v1, input kl_gnt_e last);
        if (v0 && v1) begin
            return (last == GNT_M0) ? GNT_M1 : GNT_M0;
        end else if (v1) begin
            return GNT_M1;
        end else begin
            return GNT_M0;
        end
    endfunction

endpackage

// File: rtl/kl_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// kl_id_fifo
// Generic synchronous FIFO used to remember which master issued each
// outstanding request, so responses (returned in order) can be routed back.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (flushes all entries)
//   push         : write push_data (ignored while full)
//   push_data    : entry to write
//   pop          : drop the head entry (ignored while empty)
//   full, empty  : occupancy flags; full means count == DEPTH
//   head         : entry at the read pointer
// No bypass: a pop does not free space for a push in the same cycle from the
// producer's point of view, because full is a pure function of the count.
// -----------------------------------------------------------------------------
module kl_id_fifo #(
    parameter int WIDTH = 1,
    parameter int ABITS = 2,
    parameter int DEPTH = 1 << ABITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam logic [ABITS:0] FULL_CNT = {1'b1, {ABITS{1'b0}}};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ABITS-1:0] wr_ptr;
    logic [ABITS-1:0] rd_ptr;
    logic [ABITS:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kl_arbiter.sv
// -----------------------------------------------------------------------------
// kl_arbiter
// 2-master to 1-slave KLink request arbiter with in-order response routing.
// The request path is combinational; grant lock, round-robin history and the
// response-routing FIFO are registered.
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   m0_req_* / m1_req_*              : master request fields + valid/ready
//   m0_resp_* / m1_resp_*            : master response fields + valid/ready
//   dn_req_*                         : downlink request fields + valid/ready
//   dn_resp_*                        : downlink response fields + valid/ready
//
// Handshake: a transfer happens on a cycle where valid and ready are both 1.
// Once dn_req_valid is up it is held with the same grant until it fires.
//
// Build option: define KL_ARB_FIXED_PRIO_EN for fixed priority (m0 wins ties,
// no round-robin history); otherwise round-robin.
// -----------------------------------------------------------------------------
module kl_arbiter
    import kl_arbiter_pkg::*;
#(
    parameter int OT_DEPTH = 4,
    parameter int OT_ABITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [KL_AW-1:0]    m0_req_addr,
    input  logic                m0_req_wen,
    input  logic [KL_DW-1:0]    m0_req_wdata,
    input  logic [KL_MW-1:0]    m0_req_wmask,
    input  logic [KL_SW-1:0]    m0_req_size,
    input  logic [KL_IDW-1:0]   m0_req_srcid,
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    output logic [KL_DW-1:0]    m0_resp_rdata,
    output logic [KL_SW-1:0]    m0_resp_size,
    output logic [KL_IDW-1:0]   m0_resp_dstid,
    output logic                m0_resp_valid,
    input  logic                m0_resp_ready,

    input  logic [KL_AW-1:0]    m1_req_addr,
    input  logic                m1_req_wen,
    input  logic [KL_DW-1:0]    m1_req_wdata,
    input  logic [KL_MW-1:0]    m1_req_wmask,
    input  logic [KL_SW-1:0]    m1_req_size,
    input  logic [KL_IDW-1:0]   m1_req_srcid,
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    output logic [KL_DW-1:0]    m1_resp_rdata,
    output logic [KL_SW-1:0]    m1_resp_size,
    output logic [KL_IDW-1:0]   m1_resp_dstid,
    output logic                m1_resp_valid,
    input  logic                m1_resp_ready,

    output logic [KL_AW-1:0]    dn_req_addr,
    output logic                dn_req_wen,
    output logic [KL_DW-1:0]    dn_req_wdata,
    output logic [KL_MW-1:0]    dn_req_wmask,
    output logic [KL_SW-1:0]    dn_req_size,
    output logic [KL_IDW-1:0]   dn_req_srcid,
    output logic                dn_req_valid,
    input  logic                dn_req_ready,
    input  logic [KL_DW-1:0]    dn_resp_rdata,
    input  logic [KL_SW-1:0]    dn_resp_size,
    input  logic [KL_IDW-1:0]   dn_resp_dstid,
    input  logic                dn_resp_valid,
    output logic                dn_resp_ready
);

    kl_req_t  m0_req;
    kl_req_t  m1_req;
    kl_req_t  dn_req;
    kl_gnt_e  rr_last;
    kl_gnt_e  gnt;
    kl_gnt_e  gnt_q;
    logic     lock;
    logic     gnt_valid;
    logic     req_ok;
    logic     req_fire;
    logic     resp_fire;
    logic     full;
    logic     empty;
    logic     head_m1;
    logic [0:0] push_id;
    logic [0:0] head;

    assign m0_req = {m0_req_addr, m0_req_wen, m0_req_wdata, m0_req_wmask, m0_req_size, m0_req_srcid};
    assign m1_req = {m1_req_addr, m1_req_wen, m1_req_wdata, m1_req_wmask, m1_req_size, m1_req_srcid};

    // ---------------- grant selection ----------------
    // While locked (stalled request in flight) the held grant wins over any
    // fresh arbitration so the downlink never sees the request change.
    always_comb begin
        gnt = lock ? gnt_q : kl_pick(m0_req_valid, m1_req_valid, rr_last);
    end

    assign dn_req    = (gnt == GNT_M1) ? m1_req : m0_req;
    assign gnt_valid = (gnt == GNT_M1) ? m1_req_valid : m0_req_valid;

    assign {dn_req_addr, dn_req_wen, dn_req_wdata, dn_req_wmask, dn_req_size, dn_req_srcid} = dn_req;

    assign dn_req_valid = gnt_valid & ~full;
    assign req_ok       = dn_req_ready & ~full;
    assign m0_req_ready = req_ok & (gnt == GNT_M0);
    assign m1_req_ready = req_ok & (gnt == GNT_M1);
    assign req_fire     = dn_req_valid & dn_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock  <= 1'b0;
            gnt_q <= GNT_M0;
        end else if (req_fire) begin
            lock  <= 1'b0;
        end else if (dn_req_valid) begin
            lock  <= 1'b1;
            gnt_q <= gnt;
        end
    end

`ifdef KL_ARB_FIXED_PRIO_EN
    // No history: m0 always wins a tie.
    assign rr_last = GNT_M1;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= GNT_M1;   // so m0 wins the first tie after reset
        end else if (req_fire) begin
            rr_last <= gnt;
        end
    end
`endif

    // ---------------- response routing ----------------
    assign push_id = gnt;
    assign head_m1 = head[0];

    kl_id_fifo #(
        .WIDTH (1),
        .ABITS (OT_ABITS),
        .DEPTH (OT_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (push_id),
        .pop       (resp_fire),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // A response with nothing outstanding is never accepted; it stays stuck
    // on the downlink so the protocol error is easy to spot.
    assign m0_resp_valid = dn_resp_valid & ~empty & ~head_m1;
    assign m1_resp_valid = dn_resp_valid & ~empty &  head_m1;
    assign dn_resp_ready = ~empty & (head_m1 ? m1_resp_ready : m0_resp_ready);
    assign resp_fire     = dn_resp_valid & dn_resp_ready;

    assign m0_resp_rdata = dn_resp_rdata;
    assign m0_resp_size  = dn_resp_size;
    assign m0_resp_dstid = dn_resp_dstid;
    assign m1_resp_rdata = dn_resp_rdata;
    assign m1_resp_size  = dn_resp_size;
    assign m1_resp_dstid = dn_resp_dstid;

endmodule

// File: tb/tb_kl_arbiter.sv
module tb_kl_arbiter;

    localparam int W = 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [31:0] m0_req_addr, m1_req_addr, dn_req_addr;
    logic        m0_req_wen, m1_req_wen, dn_req_wen;
    logic [63:0] m0_req_wdata, m1_req_wdata, dn_req_wdata;
    logic [7:0]  m0_req_wmask, m1_req_wmask, dn_req_wmask;
    logic [2:0]  m0_req_size, m1_req_size, dn_req_size;
    logic [4:0]  m0_req_srcid, m1_req_srcid, dn_req_srcid;
    logic        m0_req_valid, m1_req_valid, dn_req_valid;
    logic        m0_req_ready, m1_req_ready, dn_req_ready;
    logic [63:0] m0_resp_rdata, m1_resp_rdata, dn_resp_rdata;
    logic [2:0]  m0_resp_size, m1_resp_size, dn_resp_size;
    logic [4:0]  m0_resp_dstid, m1_resp_dstid, dn_resp_dstid;
    logic        m0_resp_valid, m1_resp_valid, dn_resp_valid;
    logic        m0_resp_ready, m1_resp_ready, dn_resp_ready;

    kl_arbiter #(.OT_DEPTH(4), .OT_ABITS(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0_req_addr   (m0_req_addr),
        .m0_req_wen    (m0_req_wen),
        .m0_req_wdata  (m0_req_wdata),
        .m0_req_wmask  (m0_req_wmask),
        .m0_req_size   (m0_req_size),
        .m0_req_srcid  (m0_req_srcid),
        .m0_req_valid  (m0_req_valid),
        .m0_req_ready  (m0_req_ready),
        .m0_resp_rdata (m0_resp_rdata),
        .m0_resp_size  (m0_resp_size),
        .m0_resp_dstid (m0_resp_dstid),
        .m0_resp_valid (m0_resp_valid),
        .m0_resp_ready (m0_resp_ready),
        .m1_req_addr   (m1_req_addr),
        .m1_req_wen    (m1_req_wen),
        .m1_req_wdata  (m1_req_wdata),
        .m1_req_wmask  (m1_req_wmask),
        .m1_req_size   (m1_req_size),
        .m1_req_srcid  (m1_req_srcid),
        .m1_req_valid  (m1_req_valid),
        .m1_req_ready  (m1_req_ready),
        .m1_resp_rdata (m1_resp_rdata),
        .m1_resp_size  (m1_resp_size),
        .m1_resp_dstid (m1_resp_dstid),
        .m1_resp_valid (m1_resp_valid),
        .m1_resp_ready (m1_resp_ready),
        .dn_req_addr   (dn_req_addr),
        .dn_req_wen    (dn_req_wen),
        .dn_req_wdata  (dn_req_wdata),
        .dn_req_wmask  (dn_req_wmask),
        .dn_req_size   (dn_req_size),
        .dn_req_srcid  (dn_req_srcid),
        .dn_req_valid  (dn_req_valid),
        .dn_req_ready  (dn_req_ready),
        .dn_resp_rdata (dn_resp_rdata),
        .dn_resp_size  (dn_resp_size),
        .dn_resp_dstid (dn_resp_dstid),
        .dn_resp_valid (dn_resp_valid),
        .dn_resp_ready (dn_resp_ready)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];   // expected response destination, in issue order
    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] route_of(input logic [W-1:0] m);
        return m[0] ? 2'b10 : 2'b01;
    endfunction

    task automatic pop_exp(output logic [W-1:0] m);
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: expected queue empty when a response was due");
            $fatal(1, "scoreboard underflow");
        end
        m = exp_q.pop_front();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        m0_req_valid = 0; m1_req_valid = 0; dn_req_ready = 0;
        m0_req_addr = 0; m0_req_wen = 0; m0_req_wdata = 0; m0_req_wmask = 0; m0_req_size = 0; m0_req_srcid = 0;
        m1_req_addr = 0; m1_req_wen = 0; m1_req_wdata = 0; m1_req_wmask = 0; m1_req_size = 0; m1_req_srcid = 0;
        dn_resp_valid = 0; dn_resp_rdata = 0; dn_resp_size = 0; dn_resp_dstid = 0;
        m0_resp_ready = 0; m1_resp_ready = 0;
    endtask

    task automatic set_m0(input logic v, input logic [31:0] a, input logic [4:0] id);
        m0_req_valid = v; m0_req_addr = a; m0_req_srcid = id;
        m0_req_wdata = {$urandom, $urandom}; m0_req_wmask = 8'($urandom_range(0, 255));
        m0_req_wen = 1'($urandom_range(0, 1)); m0_req_size = 3'($urandom_range(0, 3));
    endtask

    task automatic set_m1(input logic v, input logic [31:0] a, input logic [4:0] id);
        m1_req_valid = v; m1_req_addr = a; m1_req_srcid = id;
        m1_req_wdata = {$urandom, $urandom}; m1_req_wmask = 8'($urandom_range(0, 255));
        m1_req_wen = 1'($urandom_range(0, 1)); m1_req_size = 3'($urandom_range(0, 3));
    endtask

    function automatic logic [112:0] req_of(input logic m);
        if (m) return {m1_req_addr, m1_req_wen, m1_req_wdata, m1_req_wmask, m1_req_size, m1_req_srcid};
        else   return {m0_req_addr, m0_req_wen, m0_req_wdata, m0_req_wmask, m0_req_size, m0_req_srcid};
    endfunction

    // Expect a request from master exp_win to fire this cycle (dn_req_ready=1).
    task automatic expect_fire(input logic exp_win);
        @(negedge clk);
        chk("fire_dn_req_valid", dn_req_valid, 1'b1);
        chk("fire_dn_req_fields",
            {dn_req_addr, dn_req_wen, dn_req_wdata, dn_req_wmask, dn_req_size, dn_req_srcid}, req_of(exp_win));
        chk("fire_req_ready", {m1_req_ready, m0_req_ready}, route_of(exp_win));
        exp_q.push_back(exp_win);
        @(posedge clk); #1;
    endtask

    // Present one response with both masters ready; check routing and broadcast.
    task automatic expect_resp(input logic [63:0] rd);
        logic [2:0]   sz;
        logic [4:0]   id;
        logic [W-1:0] m;
        sz = 3'($urandom_range(0, 7));
        id = 5'($urandom_range(0, 31));
        dn_resp_valid = 1; dn_resp_rdata = rd; dn_resp_size = sz; dn_resp_dstid = id;
        m0_resp_ready = 1; m1_resp_ready = 1;
        @(negedge clk);
        pop_exp(m);
        chk("resp_route", {m1_resp_valid, m0_resp_valid}, route_of(m));
        chk("resp_dn_ready", dn_resp_ready, 1'b1);
        chk("resp_m0_data", {m0_resp_rdata, m0_resp_size, m0_resp_dstid}, {rd, sz, id});
        chk("resp_m1_data", {m1_resp_rdata, m1_resp_size, m1_resp_dstid}, {rd, sz, id});
        @(posedge clk); #1;
        dn_resp_valid = 0; m0_resp_ready = 0; m1_resp_ready = 0;
    endtask

    // One stalled cycle of a locked m1 request.
    task automatic lock_hold(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, dn_req_valid, 1'b1);
        chk({tag, "_fields"},
            {dn_req_addr, dn_req_wen, dn_req_wdata, dn_req_wmask, dn_req_size, dn_req_srcid}, req_of(1'b1));
        chk({tag, "_ready"}, {m1_req_ready, m0_req_ready}, 2'b00);
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] m;
        pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
        idle_inputs();
        rst_n = 0;
        // A response offered during reset must not be accepted or routed.
        dn_resp_valid = 1; m0_resp_ready = 1; m1_resp_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {dn_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, dn_resp_ready}, 6'b0);
        idle_inputs();
        rst_n = 1;
        @(posedge clk); #1;

        // Contention: m0 first after reset, then alternating; fills the FIFO.
        set_m0(1, 32'h1000_0000, 5'd1);
        set_m1(1, 32'h2000_0000, 5'd2);
        dn_req_ready = 1;
        expect_fire(1'b0);
        expect_fire(1'b1);
        expect_fire(1'b0);
        expect_fire(1'b1);

        // Full stall: fifth request (m0) held off.
        m1_req_valid = 0;
        @(negedge clk);
        chk("full_stall_valid", dn_req_valid, 1'b0);
        chk("full_stall_ready", m0_req_ready, 1'b0);
        @(posedge clk); #1;
        // One response pops, but the fifth request still waits this cycle.
        dn_resp_valid = 1; dn_resp_rdata = {$urandom, $urandom}; m0_resp_ready = 1; m1_resp_ready = 1;
        @(negedge clk);
        chk("full_no_bypass", dn_req_valid, 1'b0);
        pop_exp(m);
        chk("full_resp_route", {m1_resp_valid, m0_resp_valid}, route_of(m));
        chk("full_resp_ready", dn_resp_ready, 1'b1);
        @(posedge clk); #1;
        dn_resp_valid = 0; m0_resp_ready = 0; m1_resp_ready = 0;
        expect_fire(1'b0);      // issues on the following cycle
        m0_req_valid = 0;
        repeat (4) expect_resp({$urandom, $urandom});

        // Single master m0 read.
        set_m0(1, 32'h8000_0000, 5'd1);
        m0_req_wen = 0;
        expect_fire(1'b0);
        m0_req_valid = 0;
        expect_resp(64'hDEAD_BEEF_0000_0001);

        // Single m1 request, so m1 is now the last winner.
        set_m1(1, 32'h2000_0040, 5'd2);
        expect_fire(1'b1);
        m1_req_valid = 0;
        expect_resp({$urandom, $urandom});

        // Backpressure lock: m1 granted and stalled; m0 shows up in cycle 2
        // and would win a fresh round-robin, but the grant must stay on m1.
        set_m1(1, 32'h2000_0080, 5'd3);
        dn_req_ready = 0;
        lock_hold("lock_c1");
        set_m0(1, 32'h1000_0080, 5'd4);
        lock_hold("lock_c2");
        lock_hold("lock_c3");
        dn_req_ready = 1;
        expect_fire(1'b1);
        m0_req_valid = 0; m1_req_valid = 0;

        // m0 request behind it: outstanding order m1, m0.
        set_m0(1, 32'h1000_00C0, 5'd6);
        expect_fire(1'b0);
        m0_req_valid = 0;

        // Response backpressure with head = m1.
        dn_resp_valid = 1; dn_resp_rdata = {$urandom, $urandom}; m0_resp_ready = 1; m1_resp_ready = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rbp_dn_resp_ready", dn_resp_ready, 1'b0);
            chk("rbp_route", {m1_resp_valid, m0_resp_valid}, route_of(exp_q[0]));
            @(posedge clk); #1;
        end
        expect_resp({$urandom, $urandom});   // must still be m1's response

        // Second m0 request: two outstanding (m0, m0), m0 last winner.
        set_m0(1, 32'h1000_0100, 5'd7);
        expect_fire(1'b0);

        // Async reset between clock edges.
        m0_req_valid = 1; m1_req_valid = 1; dn_req_ready = 0;
        dn_resp_valid = 1; m0_resp_ready = 1; m1_resp_ready = 1;
        #2;
        chk("pre_rst_resp", {m1_resp_valid, m0_resp_valid, dn_resp_ready}, 3'b011);
        rst_n = 0;
        #1;
        chk("async_rst_resp", {m1_resp_valid, m0_resp_valid, dn_resp_ready}, 3'b000);
        exp_q.delete();
        m0_req_valid = 0; m1_req_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_flushed", {m1_resp_valid, m0_resp_valid, dn_resp_ready}, 3'b000);
        @(posedge clk); #1;
        dn_resp_valid = 0; m0_resp_ready = 0; m1_resp_ready = 0;
        set_m0(1, 32'h1000_0200, 5'd8);
        set_m1(1, 32'h2000_0200, 5'd9);
        dn_req_ready = 1;
        expect_fire(1'b0);      // m0 wins first after reset
        m0_req_valid = 0; m1_req_valid = 0;
        expect_resp({$urandom, $urandom});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
